// File: rtl/dot_accumulator_if.sv
// -----------------------------------------------------------------------------
// dot_accumulator_if
// Bundles the signals exchanged between the dot-product accumulator and its
// neighbours:
//   clear     : synchronous abort/restart of the current dot product
//   in_valid  : prod/prod_ovf carry a product from the multiplier
//   in_ready  : accumulator can take a product this cycle
//   prod      : PROD_W-bit unsigned product
//   prod_ovf  : multiplier overflow flag; the product value is unreliable
//   out_valid : a finished dot product is presented
//   out_ready : downstream accepts the presented result
//   acc_out   : ACC_W-bit dot-product result
//   sat       : result saturated (sum overflow or prod_ovf seen)
//   count     : products accepted in the current dot product
// The master modport is the environment side; the slave modport is the
// accumulator itself.
// -----------------------------------------------------------------------------
interface dot_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 4
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              prod_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              sat;
  logic [CNT_W-1:0]  count;

  modport master (
    output clear, in_valid, prod, prod_ovf, out_ready,
    input  in_ready, out_valid, acc_out, sat, count
  );

  modport slave (
    input  clear, in_valid, prod, prod_ovf, out_ready,
    output in_ready, out_valid, acc_out, sat, count
  );
endinterface

// File: rtl/dot_accumulator.sv
// -----------------------------------------------------------------------------
// dot_accumulator
// Sums LEN consecutive unsigned products from the 8x8 multiplier into one
// saturating dot-product result and hands it downstream over valid/ready.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dot_accumulator_if.slave (clear, input product handshake,
//           output result handshake, sat flag, beat count)
// -----------------------------------------------------------------------------
module dot_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dot_accumulator_if.slave   bus
);

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(LEN);

  logic             state_q,   state_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             sat_q,     sat_d;

  // One extra bit catches the carry out of the running sum.
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] beat_acc;
  logic             beat_sat;

  // Saturating add of the incoming product. A flagged product forces the
  // clamp because its value cannot be trusted; once clamped, further adds
  // carry out again and stay at the maximum, so the sum never wraps.
  always_comb begin
    sum_ext  = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, bus.prod};
    beat_acc = sum_ext[ACC_W-1:0];
    beat_sat = sat_q;
    if (bus.prod_ovf || sum_ext[ACC_W]) begin
      beat_acc = ACC_MAX;
      beat_sat = 1'b1;
    end
  end

  // Next-state logic. clear outranks both accepting a product and the
  // result hand-off, so a pending result is dropped even if out_ready is
  // high in the same cycle. acc_out is only touched when a result is
  // loaded so the last result stays visible after hand-off or clear.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    count_d   = count_q;
    sat_d     = sat_q;

    if (bus.clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (bus.in_valid) begin
        acc_d = beat_acc;
        sat_d = beat_sat;
        if (count_q == LAST_IDX) begin
          acc_out_d = beat_acc;
          count_d   = LEN_CNT;
          state_d   = ST_HOLD;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end else begin
      if (bus.out_ready) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        count_d = '0;
        sat_d   = 1'b0;
      end
    end
  end

  // State registers with asynchronous return to the idle, empty condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      acc_out_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  // Handshake outputs depend only on state, so nothing on the input side
  // reaches the output port combinationally.
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.acc_out   = acc_out_q;
  assign bus.sat       = sat_q;
  assign bus.count     = count_q;

endmodule
